// File: rtl/chacha_seq_pkg.sv
// rtl/chacha_seq_pkg.sv - shared state encoding and block geometry for the ChaCha sequencer
package chacha_seq_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CALC  = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  localparam logic [5:0] LOAD_BASE       = 6'd16;
  localparam int         LOAD_BYTES      = 48;
  localparam int         BLOCK_BYTES     = 64;
  localparam int         STEPS_PER_ROUND = 4;

endpackage

// File: rtl/chacha_seq_cnt.sv
// rtl/chacha_seq_cnt.sv - up-counter with enable, clear (clear wins) and terminal-count flag
module chacha_seq_cnt #(
  parameter int           W    = 6,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/chacha_block_seq.sv
// rtl/chacha_block_seq.sv - load/calc/drain sequencer for the column quarter-round array
// Optional abort input enabled by defining SEQ_ABORT_EN.
module chacha_block_seq
  import chacha_seq_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       q_write,
  output logic       q_calc,
  output logic [1:0] q_step,
  output logic [5:0] q_addr,
  output logic [7:0] q_wdata,
  input  logic [7:0] q_rdata,
  output logic       q_diag,
`ifdef SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done
);

  localparam int CALC_CYCLES = STEPS_PER_ROUND * ROUNDS;
  localparam int CYC_W       = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

`ifdef SEQ_ABORT_EN
  logic abort_i;
  assign abort_i = abort;
`else
  localparam logic abort_i = 1'b0;
`endif

  seq_state_e state_d, state_q;

  logic [5:0]       ld_cnt, rd_cnt;
  logic [CYC_W-1:0] cyc;
  logic             ld_tc, rd_tc, cyc_tc;
  logic             ld_beat, rd_beat, in_calc;

  assign ld_beat = (state_q == ST_LOAD) && in_valid && !abort_i;
  assign rd_beat = (state_q == ST_DRAIN) && out_ready && !abort_i;
  assign in_calc = (state_q == ST_CALC) && !abort_i;

  chacha_seq_cnt #(.W(6), .LAST(6'(LOAD_BYTES - 1))) u_ld_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ld_beat),
    .clr   (abort_i || (ld_beat && ld_tc)),
    .cnt   (ld_cnt),
    .tc    (ld_tc)
  );

  chacha_seq_cnt #(.W(CYC_W), .LAST(CYC_W'(CALC_CYCLES - 1))) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_calc),
    .clr   (abort_i || (in_calc && cyc_tc)),
    .cnt   (cyc),
    .tc    (cyc_tc)
  );

  chacha_seq_cnt #(.W(6), .LAST(6'(BLOCK_BYTES - 1))) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rd_beat),
    .clr   (abort_i || (rd_beat && rd_tc)),
    .cnt   (rd_cnt),
    .tc    (rd_tc)
  );

  // Zero-extend so the round-LSB tap exists even when ROUNDS=1 gives a 2-bit cyc.
  logic [CYC_W:0] cyc_x;
  logic           unused_cyc;
  assign cyc_x      = {1'b0, cyc};
  assign unused_cyc = ^cyc_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_LOAD;
    end else begin
      unique case (state_q)
        ST_LOAD:  if (ld_beat && ld_tc) state_d = ST_CALC;
        ST_CALC:  if (cyc_tc)           state_d = ST_DRAIN;
        ST_DRAIN: if (rd_beat && rd_tc) state_d = ST_LOAD;
        default:                        state_d = ST_LOAD;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    q_write   = 1'b0;
    q_calc    = 1'b0;
    q_step    = 2'd0;
    q_addr    = 6'd0;
    q_wdata   = 8'h00;
    q_diag    = 1'b0;
    busy      = (state_q != ST_LOAD);
    done      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        q_addr   = LOAD_BASE + ld_cnt;
        q_wdata  = in_data;
        q_write  = in_valid;
      end
      ST_CALC: begin
        q_calc = 1'b1;
        q_step = cyc_x[1:0];
        q_diag = cyc_x[2];
      end
      ST_DRAIN: begin
        q_addr    = rd_cnt;
        out_data  = q_rdata;
        out_valid = 1'b1;
        done      = rd_beat && rd_tc;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_chacha_block_seq.sv
// tb/tb_chacha_block_seq.sv - directed self-checking bench for chacha_block_seq
module tb_chacha_block_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       q_write;
  logic       q_calc;
  logic [1:0] q_step;
  logic [5:0] q_addr;
  logic [7:0] q_wdata;
  logic [7:0] q_rdata;
  logic       q_diag;
  logic       busy;
  logic       done;
`ifdef SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign q_rdata = {2'b00, q_addr} ^ 8'hA5;

  chacha_block_seq #(.ROUNDS(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_write   (q_write),
    .q_calc    (q_calc),
    .q_step    (q_step),
    .q_addr    (q_addr),
    .q_wdata   (q_wdata),
    .q_rdata   (q_rdata),
    .q_diag    (q_diag),
`ifdef SEQ_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},  in_ready,  1);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".q_write"},   q_write,   0);
    chk({tag, ".q_calc"},    q_calc,    0);
    chk({tag, ".q_step"},    q_step,    0);
    chk({tag, ".q_addr"},    q_addr,    16);
    chk({tag, ".q_diag"},    q_diag,    0);
    chk({tag, ".busy"},      busy,      0);
    chk({tag, ".done"},      done,      0);
  endtask

  // Enter at posedge+2 in LOAD; leave at posedge+3 of CALC cycle 0.
  task automatic load_block(input bit gaps, input int exp_cycles);
    int written = 0;
    int c = 0;
    while (written < 48 && c < 300) begin
      in_valid = gaps ? (c % 3 != 2) : 1'b1;
      in_data  = 8'(written);
      #1;
      chk("ld.q_write", q_write, in_valid);
      chk("ld.in_ready", in_ready, 1);
      chk("ld.busy", busy, 0);
      if (in_valid) begin
        chk("ld.q_addr", q_addr, 16 + written);
        chk("ld.q_wdata", q_wdata, written);
      end
      @(posedge clk); #2;
      if (in_valid) written++;
      c++;
    end
    in_valid = 1'b0;
    chk("ld.cycles", c, exp_cycles);
    #1;
    chk("ld.busy_after", busy, 1);
    chk("ld.calc_after", q_calc, 1);
    chk("ld.in_ready_after", in_ready, 0);
  endtask

  // Checks CALC cycles 0..n-1 starting at posedge+3 of cycle 0.
  task automatic calc_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      chk("calc.q_calc", q_calc, 1);
      chk("calc.q_write", q_write, 0);
      chk("calc.q_step", q_step, k % 4);
      chk("calc.q_diag", q_diag, (k / 4) % 2);
      chk("calc.in_ready", in_ready, 0);
      chk("calc.out_valid", out_valid, 0);
      @(posedge clk); #3;
    end
  endtask

  // Enter at posedge+3 of DRAIN cycle 0.
  task automatic drain_block(input bit toggle);
    int b = 0;
    int c = 0;
    int dones = 0;
    while (b < 64 && c < 300) begin
      out_ready = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      chk("dr.out_valid", out_valid, 1);
      chk("dr.in_ready", in_ready, 0);
      chk("dr.q_addr", q_addr, b);
      chk("dr.out_data", out_data, 8'(b) ^ 8'hA5);
      chk("dr.done", done, (out_ready && b == 63));
      if (done) dones++;
      @(posedge clk); #2;
      if (out_ready) b++;
      c++;
    end
    out_ready = 1'b0;
    chk("dr.beats", b, 64);
    chk("dr.done_count", dones, 1);
    #1;
    chk_idle("dr.after");
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    chk_idle("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Contiguous load, full calc, drain with toggling ready.
    load_block(1'b0, 48);
    calc_cycles(80);
    chk("calc.end_q_calc", q_calc, 0);
    chk("calc.end_out_valid", out_valid, 1);
    drain_block(1'b1);

    // Back-to-back: gapped load starts immediately after done.
    #1;
    load_block(1'b1, 71);
    calc_cycles(37);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("midreset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk_idle("post_reset");

    load_block(1'b0, 48);
    calc_cycles(80);
    drain_block(1'b0);

`ifdef SEQ_ABORT_EN
    #1;
    load_block(1'b0, 48);
    calc_cycles(80);
    out_ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      @(posedge clk); #3;
    end
    abort = 1'b1;
    #1;
    chk("ab.q_addr_at", q_addr, 10);
    chk("ab.done_at", done, 0);
    @(posedge clk); #2;
    abort     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk_idle("ab.after");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule
